// File: rtl/branch_stack_ctrl_pkg.sv
// Shared types for the branch-checkpoint stack: mask, checkpoint and resolve packets,
// plus the one-hot to index encoder used to locate the resolving checkpoint.
package branch_stack_ctrl_pkg;

  localparam int B_MASK_WIDTH   = 4;
  localparam int B_MASK_ID_BITS = 2;
  localparam int ARCH_REG_SZ    = 8;
  localparam int PHYS_REG_SZ    = 16;
  localparam int PHYS_IDX_BITS  = 4;
  localparam int ROB_SZ_BITS    = 4;
  localparam int ADDR_BITS      = 32;

  typedef logic [B_MASK_WIDTH-1:0]   b_mask_t;
  typedef logic [B_MASK_ID_BITS-1:0] b_id_t;
  typedef logic [PHYS_IDX_BITS-1:0]  phys_reg_idx_t;
  typedef phys_reg_idx_t [ARCH_REG_SZ-1:0] map_table_t;
  typedef logic [PHYS_REG_SZ-1:0]    free_list_t;
  typedef logic [ROB_SZ_BITS-1:0]    rob_idx_t;
  typedef logic [ADDR_BITS-1:0]      addr_t;

  typedef struct packed {
    map_table_t map_table;
    free_list_t free_list;
    rob_idx_t   rob_tail;
    addr_t      recovery_pc;
    b_mask_t    b_m;
  } bs_entry_t;

  typedef struct packed {
    logic    valid;
    logic    mispredict;
    b_mask_t b_mask_mask;
    addr_t   target_pc;
  } bs_resolve_t;

  function automatic b_id_t onehot_enc(input b_mask_t oh);
    b_id_t enc;
    enc = '0;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      if (oh[i]) enc = enc | i[B_MASK_ID_BITS-1:0];
    end
    return enc;
  endfunction

endpackage

// File: rtl/branch_stack_ctrl_squash_mask.sv
// Column scan of every checkpoint's older-branch mask: entry j depends on
// branch col_idx exactly when its b_m has that bit set.
module bs_squash_mask
  import branch_stack_ctrl_pkg::*;
(
  input  b_mask_t entry_b_m [B_MASK_WIDTH],
  input  b_id_t   col_idx,
  output b_mask_t squash
);

  always_comb begin
    squash = '0;
    for (int j = 0; j < B_MASK_WIDTH; j++) begin
      squash[j] = entry_b_m[j][col_idx];
    end
  end

endmodule

// File: rtl/branch_stack_ctrl.sv
// Branch-checkpoint stack: tracks live branch ids, resolves one branch per cycle
// and drives a zero-latency restore from the checkpoint on a mispredict.
module branch_stack_ctrl
  import branch_stack_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  bs_entry_t  branch_stack_entries [B_MASK_WIDTH],
  input  b_mask_t    next_b_mask,
  input  logic       resolve_valid,
  input  logic       resolve_mispredict,
  input  b_mask_t    resolve_b_mask_mask,
  input  addr_t      resolve_target_PC,
  input  free_list_t retire_free_mask,
  output b_mask_t    b_mask_combinational,
  output logic       restore_valid,
  output map_table_t map_table_restore,
  output free_list_t restore_free_list,
  output rob_idx_t   restore_rob_tail,
  output addr_t      restore_PC,
  output b_mask_t    b_mm_resolve,
  output b_mask_t    b_mm_squash
);

  b_mask_t     b_mask_q, b_mask_d;
  bs_entry_t   entry_q [B_MASK_WIDTH];
  bs_entry_t   entry_d [B_MASK_WIDTH];
  b_mask_t     entry_b_m [B_MASK_WIDTH];
  bs_resolve_t res;
  b_id_t       res_idx;
  b_mask_t     res_oh;
  logic        res_live;
  logic        res_correct;
  logic        res_mispred;
  b_mask_t     squash_col;
  b_mask_t     alloc_mask;

  always_comb begin
    res         = '{valid: resolve_valid, mispredict: resolve_mispredict,
                    b_mask_mask: resolve_b_mask_mask, target_pc: resolve_target_PC};
    res_idx     = onehot_enc(res.b_mask_mask);
    res_oh      = b_mask_t'(1) << res_idx;
    // Resolves on ids that are not live are dropped; reset also forces all outputs to 0.
    res_live    = !reset && res.valid && b_mask_q[res_idx];
    res_correct = res_live && !res.mispredict;
    res_mispred = res_live && res.mispredict;
    for (int j = 0; j < B_MASK_WIDTH; j++) entry_b_m[j] = entry_q[j].b_m;
  end

  bs_squash_mask u_squash (
    .entry_b_m (entry_b_m),
    .col_idx   (res_idx),
    .squash    (squash_col)
  );

  always_comb begin
    b_mm_resolve         = res_correct ? res_oh : '0;
    b_mm_squash          = res_mispred ? (res_oh | squash_col) : '0;
    b_mask_combinational = reset ? '0 : (b_mask_q & ~(b_mm_resolve | b_mm_squash));
    restore_valid        = res_mispred;
    map_table_restore    = '0;
    restore_free_list    = '0;
    restore_rob_tail     = '0;
    restore_PC           = '0;
    if (res_mispred) begin
      map_table_restore = entry_q[res_idx].map_table;
      restore_free_list = entry_q[res_idx].free_list | retire_free_mask;
      restore_rob_tail  = entry_q[res_idx].rob_tail;
      restore_PC        = res.target_pc;
    end
  end

  // A restore overrides dispatch: its mask and checkpoint writes for this cycle are dropped.
  always_comb begin
    b_mask_d   = res_mispred ? b_mask_combinational : next_b_mask;
    alloc_mask = res_mispred ? '0 : (next_b_mask & ~b_mask_combinational);
    for (int j = 0; j < B_MASK_WIDTH; j++) begin
      entry_d[j]           = alloc_mask[j] ? branch_stack_entries[j] : entry_q[j];
      entry_d[j].b_m       = entry_d[j].b_m & ~b_mm_resolve;
      entry_d[j].free_list = entry_d[j].free_list | retire_free_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      b_mask_q <= '0;
      for (int j = 0; j < B_MASK_WIDTH; j++) entry_q[j] <= '0;
    end else begin
      b_mask_q <= b_mask_d;
      for (int j = 0; j < B_MASK_WIDTH; j++) entry_q[j] <= entry_d[j];
    end
  end

`ifdef DEBUG
  always_ff @(posedge clock) begin
    if (!reset && resolve_valid) begin
      assert (b_mask_q[res_idx]) else $error("resolve on non-live branch id %0d", res_idx);
    end
  end
`endif

endmodule

// File: tb/tb_branch_stack_ctrl.sv
// Directed bench for branch_stack_ctrl: allocation, correct and mispredicted
// resolves, dropped dispatch on restore, retire free-list merge and full-stack reuse.
module tb_branch_stack_ctrl;
  import branch_stack_ctrl_pkg::*;

  logic       clock;
  logic       reset;
  bs_entry_t  bse [B_MASK_WIDTH];
  b_mask_t    next_b_mask;
  logic       resolve_valid;
  logic       resolve_mispredict;
  b_mask_t    resolve_b_mask_mask;
  addr_t      resolve_target_PC;
  free_list_t retire_free_mask;
  b_mask_t    b_mask_combinational;
  logic       restore_valid;
  map_table_t map_table_restore;
  free_list_t restore_free_list;
  rob_idx_t   restore_rob_tail;
  addr_t      restore_PC;
  b_mask_t    b_mm_resolve;
  b_mask_t    b_mm_squash;

  int n_vec = 0;
  int n_err = 0;

  branch_stack_ctrl dut (
    .clock                (clock),
    .reset                (reset),
    .branch_stack_entries (bse),
    .next_b_mask          (next_b_mask),
    .resolve_valid        (resolve_valid),
    .resolve_mispredict   (resolve_mispredict),
    .resolve_b_mask_mask  (resolve_b_mask_mask),
    .resolve_target_PC    (resolve_target_PC),
    .retire_free_mask     (retire_free_mask),
    .b_mask_combinational (b_mask_combinational),
    .restore_valid        (restore_valid),
    .map_table_restore    (map_table_restore),
    .restore_free_list    (restore_free_list),
    .restore_rob_tail     (restore_rob_tail),
    .restore_PC           (restore_PC),
    .b_mm_resolve         (b_mm_resolve),
    .b_mm_squash          (b_mm_squash)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checkpoint with a map table pattern tied to its rob tail so restores are recognisable.
  function automatic bs_entry_t mk_entry(input int rob, input b_mask_t bm,
                                         input free_list_t fl, input addr_t pc);
    bs_entry_t e;
    for (int i = 0; i < ARCH_REG_SZ; i++) e.map_table[i] = phys_reg_idx_t'(rob + i);
    e.free_list   = fl;
    e.rob_tail    = rob_idx_t'(rob);
    e.recovery_pc = pc;
    e.b_m         = bm;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input b_mask_t keep_mask);
    next_b_mask         = keep_mask;
    resolve_valid       = 1'b0;
    resolve_mispredict  = 1'b0;
    resolve_b_mask_mask = '0;
    resolve_target_PC   = '0;
    retire_free_mask    = '0;
    for (int j = 0; j < B_MASK_WIDTH; j++) bse[j] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle('0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic resolve(input b_mask_t id, input logic mis, input addr_t pc, input b_mask_t nxt);
    resolve_valid       = 1'b1;
    resolve_mispredict  = mis;
    resolve_b_mask_mask = id;
    resolve_target_PC   = pc;
    next_b_mask         = nxt;
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("idle_mask", b_mask_combinational, 4'b0000);
      check_eq("idle_restore_valid", restore_valid, 1'b0);
      check_eq("idle_resolve", b_mm_resolve, 4'b0000);
      check_eq("idle_squash", b_mm_squash, 4'b0000);
      tick();
    end

    // 2: single alloc then correct resolve
    idle(4'b0001);
    bse[0] = mk_entry(3, 4'b0000, '0, 32'h40);
    tick();
    idle(4'b0001);
    #1 check_eq("t2_live", b_mask_combinational, 4'b0001);
    resolve(4'b0001, 1'b0, 32'h0, 4'b0000);
    #1;
    check_eq("t2_resolve", b_mm_resolve, 4'b0001);
    check_eq("t2_comb", b_mask_combinational, 4'b0000);
    check_eq("t2_no_restore", restore_valid, 1'b0);
    check_eq("t2_no_squash", b_mm_squash, 4'b0000);
    tick();
    idle(4'b0000);
    #1 check_eq("t2_after", b_mask_combinational, 4'b0000);

    // 3: nested allocs, mispredict id1
    do_reset();
    idle(4'b0001); bse[0] = mk_entry(5, 4'b0000, '0, 32'h100); tick();
    idle(4'b0011); bse[1] = mk_entry(7, 4'b0001, 16'h00f0, 32'h200); tick();
    idle(4'b0111); bse[2] = mk_entry(9, 4'b0011, '0, 32'h300); tick();
    idle(4'b0111);
    #1 check_eq("t3_live", b_mask_combinational, 4'b0111);
    resolve(4'b0010, 1'b1, 32'h1000, 4'b0111);
    #1;
    check_eq("t3_squash", b_mm_squash, 4'b0110);
    check_eq("t3_restore_valid", restore_valid, 1'b1);
    check_eq("t3_rob_tail", restore_rob_tail, 4'd7);
    check_eq("t3_map", map_table_restore, mk_entry(7, '0, '0, '0).map_table);
    check_eq("t3_free_list", restore_free_list, 16'h00f0);
    check_eq("t3_pc", restore_PC, 32'h1000);
    check_eq("t3_comb", b_mask_combinational, 4'b0001);
    check_eq("t3_no_resolve", b_mm_resolve, 4'b0000);
    tick();
    idle(4'b0001);
    #1 check_eq("t3_after", b_mask_combinational, 4'b0001);
    check_eq("t3_after_restore", restore_valid, 1'b0);
    check_eq("t3_after_tail", restore_rob_tail, 4'd0);

    // 4: mispredict beats a same-cycle full dispatch
    do_reset();
    idle(4'b0001); bse[0] = mk_entry(4, 4'b0000, '0, 32'h10); tick();
    idle(4'b0011); bse[1] = mk_entry(6, 4'b0001, '0, 32'h20); tick();
    idle(4'b0011);
    resolve(4'b0010, 1'b1, 32'h3000, 4'b1111);
    bse[2] = mk_entry(14, 4'b0011, 16'hffff, 32'h30);
    bse[3] = mk_entry(14, 4'b0111, 16'hffff, 32'h40);
    #1;
    check_eq("t4_squash", b_mm_squash, 4'b0010);
    check_eq("t4_rob_tail", restore_rob_tail, 4'd6);
    check_eq("t4_comb", b_mask_combinational, 4'b0001);
    tick();
    idle(4'b0001);
    #1 check_eq("t4_mask_kept", b_mask_combinational, 4'b0001);
    resolve(4'b0001, 1'b1, 32'h3100, 4'b0001);
    #1;
    check_eq("t4_entries_unwritten", b_mm_squash, 4'b0011);
    check_eq("t4_rob_tail0", restore_rob_tail, 4'd4);
    check_eq("t4_free_list0", restore_free_list, 16'h0000);
    tick();

    // 5: retirement merges into a live checkpoint's free list
    do_reset();
    idle(4'b0001); bse[0] = mk_entry(2, 4'b0000, '0, 32'h50); tick();
    idle(4'b0001); tick();
    idle(4'b0001); retire_free_mask = 16'h0080; tick();
    idle(4'b0001);
    resolve(4'b0001, 1'b1, 32'h2000, 4'b0001);
    #1;
    check_eq("t5_free_list", restore_free_list, 16'h0080);
    check_eq("t5_rob_tail", restore_rob_tail, 4'd2);
    check_eq("t5_pc", restore_PC, 32'h2000);
    retire_free_mask = 16'h0100;
    #1 check_eq("t5_free_list_live", restore_free_list, 16'h0180);
    tick();
    idle(4'b0000);
    #1 check_eq("t5_after", b_mask_combinational, 4'b0000);

    // 6: full stack, correct resolve id2 reused the same cycle
    do_reset();
    idle(4'b0001); bse[0] = mk_entry(1, 4'b0000, '0, 32'h60); tick();
    idle(4'b0011); bse[1] = mk_entry(2, 4'b0001, '0, 32'h64); tick();
    idle(4'b0111); bse[2] = mk_entry(3, 4'b0011, '0, 32'h68); tick();
    idle(4'b1111); bse[3] = mk_entry(4, 4'b0111, '0, 32'h6c); tick();
    idle(4'b1111);
    #1 check_eq("t6_full", b_mask_combinational, 4'b1111);
    resolve(4'b0100, 1'b0, 32'h0, 4'b1111);
    bse[2] = mk_entry(12, 4'b1011, 16'h0003, 32'h600);
    #1;
    check_eq("t6_resolve", b_mm_resolve, 4'b0100);
    check_eq("t6_comb", b_mask_combinational, 4'b1011);
    tick();
    idle(4'b1111);
    #1 check_eq("t6_still_full", b_mask_combinational, 4'b1111);
    resolve(4'b0100, 1'b1, 32'h6000, 4'b1111);
    #1;
    check_eq("t6_new_tail", restore_rob_tail, 4'd12);
    check_eq("t6_new_free", restore_free_list, 16'h0003);
    check_eq("t6_new_map", map_table_restore, mk_entry(12, '0, '0, '0).map_table);
    check_eq("t6_squash", b_mm_squash, 4'b0100);
    check_eq("t6_comb_mis", b_mask_combinational, 4'b1011);
    tick();
    idle(4'b1011);
    #1 check_eq("t6_after", b_mask_combinational, 4'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
